// File: rtl/table_checker.sv
// Truth-table sweeper: drives every {w,x,y} vector, holds each SETTLE cycles,
// and checks z against EXPECTED, reporting error count, first failure and pass.
module table_checker #(
  parameter int         SETTLE   = 2,
  parameter logic [7:0] EXPECTED = 8'b1110_1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       w,
  output logic       x,
  output logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     r_state, w_state_next;
  logic [2:0] r_vec, w_vec_next;
  logic [3:0] r_settle, w_settle_next;
  logic [2:0] r_wxy, w_wxy_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;
  logic       r_pass, w_pass_next;
  logic [3:0] r_err, w_err_next;
  logic       r_fail_valid, w_fail_valid_next;
  logic [2:0] r_first_fail, w_first_fail_next;

  logic w_sample;
  logic w_mismatch;

  assign w_sample   = (r_settle == SETTLE_LAST);
  assign w_mismatch = (z != EXPECTED[r_vec]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vec        <= 3'd0;
      r_settle     <= 4'd0;
      r_wxy        <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= 4'd0;
      r_fail_valid <= 1'b0;
      r_first_fail <= 3'd0;
    end else begin
      r_state      <= w_state_next;
      r_vec        <= w_vec_next;
      r_settle     <= w_settle_next;
      r_wxy        <= w_wxy_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
      r_err        <= w_err_next;
      r_fail_valid <= w_fail_valid_next;
      r_first_fail <= w_first_fail_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_vec_next        = r_vec;
    w_settle_next     = r_settle;
    w_wxy_next        = r_wxy;
    w_busy_next       = r_busy;
    w_done_next       = r_done;
    w_pass_next       = r_pass;
    w_err_next        = r_err;
    w_fail_valid_next = r_fail_valid;
    w_first_fail_next = r_first_fail;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next      = RUN;
          w_vec_next        = 3'd0;
          w_settle_next     = 4'd0;
          w_wxy_next        = 3'd0;
          w_busy_next       = 1'b1;
          w_done_next       = 1'b0;
          w_pass_next       = 1'b0;
          w_err_next        = 4'd0;
          w_fail_valid_next = 1'b0;
          w_first_fail_next = 3'd0;
        end
      end
      RUN: begin
        if (w_sample) begin
          w_settle_next = 4'd0;
          if (w_mismatch) begin
            w_err_next = r_err + 4'd1;
            if (!r_fail_valid) begin
              w_fail_valid_next = 1'b1;
              w_first_fail_next = r_vec;
            end
          end
          // The last sample ends the sweep and returns the stimulus to 000.
          if (r_vec == 3'd7) begin
            w_state_next = DONE;
            w_vec_next   = 3'd0;
            w_wxy_next   = 3'd0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_pass_next  = (w_err_next == 4'd0);
          end else begin
            w_vec_next = r_vec + 3'd1;
            w_wxy_next = r_vec + 3'd1;
          end
        end else begin
          w_settle_next = r_settle + 4'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w          = r_wxy[2];
  assign x          = r_wxy[1];
  assign y          = r_wxy[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign first_fail = r_first_fail;

endmodule
